// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB request arbiter: FSM states,
// bus field widths and the latched command record.
package apb_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Wait-counter width; a disabled timeout still gets a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_request_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from last_i+1 upward,
// wrapping modulo NREQ, and returns the first requester found.
module rr_picker #(
  parameter int NREQ = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter sharing one APB master among NREQ requesters; one
// transfer in flight, with wait states, timeout abort and a done pulse.
module apb_request_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ID_W-1:0]   req_id,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ID_W-1:0]        pid,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [DATA_W-1:0]      prdata,
  input  logic                   pready,
  input  logic                   pslverr,
  output state_e                 dbg_state
);

  localparam int   IDX_W = $clog2(NREQ);
  localparam int   CNT_W = cnt_width(TIMEOUT);
  localparam logic TO_EN = (TIMEOUT != 0);

  state_e            state_q;
  cmd_t              cmd_q;
  cmd_t              win_cmd;
  logic [NREQ-1:0]   gnt_q, done_q;
  logic [IDX_W-1:0]  idx_q, last_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q, psel_q, penable_q;
  logic              to_hit;

  logic [NREQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // One-hot mux of the winning requester's command fields.
  always_comb begin
    win_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        win_cmd.write = req_write[i];
        win_cmd.id    = req_id[i*ID_W +: ID_W];
        win_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_cmd.wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cnt_d  = cnt_q + CNT_W'(1);
  assign to_hit = TO_EN && (cnt_d == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            cmd_q   <= win_cmd;
            gnt_q   <= pick_gnt;
            idx_q   <= pick_idx;
            cnt_q   <= '0;
            psel_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            rdata_q   <= cmd_q.write ? '0 : prdata;
            err_q     <= pslverr;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            state_q   <= ST_DONE;
          end else if (to_hit) begin
            // Stalled slave: abort and report an error with no data.
            rdata_q   <= '0;
            err_q     <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          last_q  <= idx_q;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = cmd_q.write;
  assign pid       = cmd_q.id;
  assign paddr     = cmd_q.addr;
  assign pwdata    = cmd_q.wdata;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Randomized scoreboard bench for apb_request_arbiter with a behavioural
// APB slave and a batch-level round-robin reference model.
module tb_apb_request_arbiter;
  import apb_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 6;
  localparam int BUDGET  = 400;

  typedef struct packed {
    logic [2:0] idx;
    logic       write;
    logic [1:0] id;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    logic       slverr;
    logic [7:0] waits;
  } xfer_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req, req_write, gnt, done;
  logic [NREQ*2-1:0]   req_id;
  logic [NREQ*8-1:0]   req_addr, req_wdata;
  logic [7:0]          rsp_rdata, paddr, pwdata, prdata;
  logic                rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [1:0]          pid;
  state_e              dbg_state;

  apb_request_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_id(req_id),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pid(pid), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  xfer_t exp_q[$];
  xfer_t slv_q[$];
  xfer_t cmd_tab[NREQ];
  int    model_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_timeout(input xfer_t e);
    return (TIMEOUT != 0) && (int'(e.waits) >= TIMEOUT);
  endfunction

  function automatic logic [7:0] exp_rdata(input xfer_t e);
    if (is_timeout(e) || e.write) return 8'h00;
    return e.prdata;
  endfunction

  function automatic logic exp_err(input xfer_t e);
    return is_timeout(e) ? 1'b1 : e.slverr;
  endfunction

  function automatic int exp_lat(input xfer_t e);
    return is_timeout(e) ? TIMEOUT + 1 : int'(e.waits) + 2;
  endfunction

  task automatic set_cmd(input int i, input logic w, input logic [1:0] id,
                         input logic [7:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] rd, input logic err);
    cmd_tab[i] = '{idx: 3'(i), write: w, id: id, addr: a, wdata: wd,
                   prdata: rd, slverr: err, waits: 8'(waits)};
  endtask

  task automatic drive_req(input int i);
    req_write[i]         = cmd_tab[i].write;
    req_id[i*2 +: 2]     = cmd_tab[i].id;
    req_addr[i*8 +: 8]   = cmd_tab[i].addr;
    req_wdata[i*8 +: 8]  = cmd_tab[i].wdata;
  endtask

  // Reference: a static batch is served in ascending order from last+1.
  task automatic run_batch(input logic [NREQ-1:0] mask);
    int budget;
    int last_in;
    last_in = model_last;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (model_last + k) % NREQ;
      if (mask[i]) begin
        exp_q.push_back(cmd_tab[i]);
        slv_q.push_back(cmd_tab[i]);
        last_in = i;
      end
    end
    model_last = last_in;
    for (int i = 0; i < NREQ; i++) if (mask[i]) drive_req(i);
    req = req | mask;
    budget = 0;
    while ((req != '0 || exp_q.size() != 0) && budget < BUDGET) begin
      @(negedge clk);
      budget++;
      if (psel && !penable) begin
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            req_addr[i*8 +: 8]  = 8'($urandom);
            req_wdata[i*8 +: 8] = 8'($urandom);
            req_write[i]        = 1'($urandom);
            if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
          end
        end
      end
      req = req & ~done;
    end
    chk("batch_budget", (budget < BUDGET), 1'b1);
    if (budget >= BUDGET) begin
      req = '0;
      exp_q.delete();
      slv_q.delete();
    end
  endtask

  // Behavioural APB slave: holds pready low for 'waits' ACCESS cycles.
  xfer_t sl_cur;
  int    sl_w;
  initial begin
    pready  = 1'b0;
    prdata  = 8'h00;
    pslverr = 1'b0;
    sl_cur  = '0;
    sl_w    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pready = 1'b0;
      end else if (psel && !penable) begin
        sl_cur  = (slv_q.size() != 0) ? slv_q.pop_front() : '0;
        sl_w    = 0;
        pready  = 1'b0;
        prdata  = sl_cur.prdata;
        pslverr = sl_cur.slverr;
      end else if (psel && penable) begin
        pready = (sl_w == int'(sl_cur.waits));
        sl_w++;
      end else begin
        pready = 1'b0;
      end
    end
  end

  // Monitor: compares the APB command at SETUP and the response at done.
  int          cyc = 0;
  int          setup_cyc = 0;
  int          done_cyc = -10;
  logic [31:0] snap;
  initial begin
    xfer_t e;
    snap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (psel && !penable) begin
          chk("idle_gap", (cyc - done_cyc >= 2), 1'b1);
          if (exp_q.size() == 0) begin
            chk("unexpected_setup", 1'b1, 1'b0);
          end else begin
            e = exp_q[0];
            chk("setup_cmd", {pwrite, pid, paddr, pwdata, gnt},
                {e.write, e.id, e.addr, e.wdata, NREQ'(1) << e.idx});
          end
          snap      = {8'(gnt), psel, pwrite, 4'(pid), paddr, pwdata};
          setup_cyc = cyc;
        end else if (psel && penable) begin
          chk("access_stable", {8'(gnt), psel, pwrite, 4'(pid), paddr, pwdata}, snap);
        end
        if (done != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", done, '0);
          end else begin
            e = exp_q.pop_front();
            chk("done_owner", done, NREQ'(1) << e.idx);
            chk("rsp_rdata", rsp_rdata, exp_rdata(e));
            chk("rsp_err", rsp_err, exp_err(e));
            chk("done_psel", psel, 1'b0);
            chk("latency", cyc - setup_cyc, exp_lat(e));
          end
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last = NREQ - 1;
  endtask

  initial begin
    int b;
    rst = 1'b1; req = '0; req_write = '0; req_id = '0; req_addr = '0; req_wdata = '0;
    model_last = NREQ - 1;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_ctrl", {psel, penable, pwrite, rsp_err}, 4'b0);
    chk("rst_gnt_done", {gnt, done}, '0);
    chk("rst_data", {pid, paddr, pwdata, rsp_rdata}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single read with explicit cycle-by-cycle timing
    set_cmd(0, 1'b0, 2'd1, 8'h10, 8'h00, 0, 8'hA5, 1'b0);
    exp_q.push_back(cmd_tab[0]);
    slv_q.push_back(cmd_tab[0]);
    drive_req(0);
    req[0] = 1'b1;
    @(negedge clk);
    chk("single_setup", {psel, penable}, 2'b10);
    @(negedge clk);
    chk("single_access", {psel, penable}, 2'b11);
    @(negedge clk);
    chk("single_done_c3", done, 4'b0001);
    chk("single_rdata", rsp_rdata, 8'hA5);
    req[0] = 1'b0;
    model_last = 0;
    repeat (2) @(negedge clk);

    // All requesters at once after reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_cmd(i, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 0, 8'($urandom), 1'b0);
    run_batch('1);

    // Wait states on a write
    set_cmd(1, 1'b1, 2'd2, 8'h02, 8'h3C, 5, 8'h77, 1'b0);
    run_batch(4'b0010);

    // Timeout on a read with non-zero slave data
    set_cmd(2, 1'b0, 2'd3, 8'h20, 8'h00, TIMEOUT + 5, 8'h5A, 1'b0);
    run_batch(4'b0100);

    // pslverr, then a follow-up request
    set_cmd(3, 1'b0, 2'd0, 8'h30, 8'h00, 0, 8'hC3, 1'b1);
    run_batch(4'b1000);
    set_cmd(0, 1'b1, 2'd1, 8'h31, 8'h42, 1, 8'h00, 1'b0);
    run_batch(4'b0001);

    // Reset mid-ACCESS: no done, bus released, req[0] wins afterwards
    set_cmd(2, 1'b1, 2'd2, 8'h44, 8'h99, 50, 8'h00, 1'b0);
    exp_q.push_back(cmd_tab[2]);
    slv_q.push_back(cmd_tab[2]);
    drive_req(2);
    req[2] = 1'b1;
    b = 0;
    while (!(psel && penable) && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("reach_access", (b < 20), 1'b1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("midrst_psel", psel, 1'b0);
    chk("midrst_done", done, '0);
    exp_q.delete();
    slv_q.delete();
    rst = 1'b0;
    model_last = NREQ - 1;
    set_cmd(0, 1'b0, 2'd1, 8'h50, 8'h00, 0, 8'h11, 1'b0);
    set_cmd(3, 1'b0, 2'd2, 8'h53, 8'h00, 0, 8'h33, 1'b0);
    run_batch(4'b1001);

    // Randomized batches
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        int r, w;
        r = $urandom_range(0, 9);
        w = (r == 0) ? TIMEOUT + 3 : ((r < 4) ? r : 0);
        set_cmd(i, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), w,
                8'($urandom), ($urandom_range(0, 3) == 0));
      end
      run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("slv_q_drained", slv_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
